// File: rtl/fir_chan_sched_if.sv
// Signal bundle between the multi-channel FIR scheduler and its requesters / shared MAC datapath.
// The master side is the scheduler; the slave side is the requesters and the datapath.
interface fir_chan_sched_if #(
  parameter int unsigned Num_coef = 17,
  parameter int unsigned Num_ch   = 2
);
  localparam int unsigned ChW   = (Num_ch > 1) ? $clog2(Num_ch) : 1;
  localparam int unsigned AddrW = (Num_coef > 1) ? $clog2(Num_coef) : 1;

  logic [Num_ch-1:0] req;
  logic [Num_ch-1:0] ack;
  logic [ChW-1:0]    ch_sel;
  logic [AddrW-1:0]  addr;
  logic              ce_Reg;
  logic              rst_Acc;
  logic              ce_Acc;
  logic              val_out;
  logic [ChW-1:0]    ch_out;

  modport master (
    input  req,
    output ack, ch_sel, addr, ce_Reg, rst_Acc, ce_Acc, val_out, ch_out
  );

  modport slave (
    output req,
    input  ack, ch_sel, addr, ce_Reg, rst_Acc, ce_Acc, val_out, ch_out
  );
endinterface

// File: rtl/fir_chan_sched.sv
// Round-robin scheduler sharing one MAC FIR datapath between Num_ch channels.
// Each grant runs one full Num_coef-tap convolution: LOAD, Num_coef MAC cycles, DONE.
module fir_chan_sched #(
  parameter int unsigned Num_coef = 17,
  parameter int unsigned Num_ch   = 2
) (
  input logic              clk,
  input logic              rst,
  fir_chan_sched_if.master bus
);
  localparam int unsigned ChW   = (Num_ch > 1) ? $clog2(Num_ch) : 1;
  localparam int unsigned AddrW = (Num_coef > 1) ? $clog2(Num_coef) : 1;
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Num_coef - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StMac, StDone} state_e;

  state_e            state_q, state_d;
  logic [ChW-1:0]    last_q, last_d;
  logic [Num_ch-1:0] ack_q, ack_d;
  logic [ChW-1:0]    ch_sel_q, ch_sel_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic              ce_reg_q, ce_reg_d;
  logic              rst_acc_q, rst_acc_d;
  logic              ce_acc_q, ce_acc_d;
  logic              val_q, val_d;
  logic [ChW-1:0]    ch_out_q, ch_out_d;

  logic              found;
  logic [ChW-1:0]    grant;
  logic [ChW-1:0]    idx;

  // Search upward from the channel after the last one served, wrapping around.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 1; i <= int'(Num_ch); i++) begin
      idx = ChW'((int'(last_q) + i) % int'(Num_ch));
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Output registers are loaded from the decode of the state being entered,
  // so every strobe is visible in the same cycle as its state.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    ack_d     = '0;
    ch_sel_d  = ch_sel_q;
    addr_d    = '0;
    ce_reg_d  = 1'b0;
    rst_acc_d = 1'b0;
    ce_acc_d  = 1'b0;
    val_d     = 1'b0;
    ch_out_d  = ch_out_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (found) begin
          state_d      = StLoad;
          last_d       = grant;
          ack_d[grant] = 1'b1;
          ce_reg_d     = 1'b1;
          rst_acc_d    = 1'b1;
          ch_sel_d     = grant;
        end else begin
          state_d = StIdle;
        end
      end
      StLoad: begin
        state_d  = StMac;
        ce_acc_d = 1'b1;
      end
      StMac: begin
        if (addr_q == LastAddr) begin
          state_d  = StDone;
          val_d    = 1'b1;
          ch_out_d = ch_sel_q;
        end else begin
          ce_acc_d = 1'b1;
          addr_d   = addr_q + AddrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      last_q    <= ChW'(Num_ch - 1);
      ack_q     <= '0;
      ch_sel_q  <= '0;
      addr_q    <= '0;
      ce_reg_q  <= 1'b0;
      rst_acc_q <= 1'b0;
      ce_acc_q  <= 1'b0;
      val_q     <= 1'b0;
      ch_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
      ch_sel_q  <= ch_sel_d;
      addr_q    <= addr_d;
      ce_reg_q  <= ce_reg_d;
      rst_acc_q <= rst_acc_d;
      ce_acc_q  <= ce_acc_d;
      val_q     <= val_d;
      ch_out_q  <= ch_out_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.ch_sel  = ch_sel_q;
  assign bus.addr    = addr_q;
  assign bus.ce_Reg  = ce_reg_q;
  assign bus.rst_Acc = rst_acc_q;
  assign bus.ce_Acc  = ce_acc_q;
  assign bus.val_out = val_q;
  assign bus.ch_out  = ch_out_q;
endmodule
